// File: rtl/bcd_stream_pkg.sv
// Shared types and constants for the streaming BCD residue checker.
package bcd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } state_e;

  localparam int BCD_MAX = 9;
  localparam int STEP_W  = 8;

endpackage : bcd_stream_pkg

// File: rtl/bcd_mod_step.sv
// One Horner step of a decimal residue: (r*10 + d) mod DIVISOR, purely combinational.
module bcd_mod_step
  import bcd_stream_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int RES_W   = 4
) (
  input  logic [RES_W-1:0] r_i,
  input  logic [3:0]       d_i,
  output logic [RES_W-1:0] mod_o
);

  logic [STEP_W-1:0] acc;

  // r < DIVISOR keeps r*10 + d below 16*DIVISOR, so one pass of
  // binary long division (subtract 8D, 4D, 2D, D) fully reduces it.
  always_comb begin
    // NOTE: give every combinational output a value before any branch so no latch is inferred.
    acc = STEP_W'(r_i) * STEP_W'(10) + STEP_W'(d_i);
    for (int k = 3; k >= 0; k--) begin
      if (acc >= STEP_W'(DIVISOR << k)) begin
        acc = acc - STEP_W'(DIVISOR << k);
      end
    end
    mod_o = acc[RES_W-1:0];
  end

endmodule : bcd_mod_step

// File: rtl/bcd_stream_mod_checker.sv
// Streaming BCD divisibility checker: digits in MSD-first, residue/result out via valid/ready.
// Define BCD_STREAM_ERR_CHECK_EN to flag digits above 9 as a sticky per-number error.
module bcd_stream_mod_checker
  import bcd_stream_pkg::*;
#(
  parameter int DIVISOR    = 3,
  parameter int MAX_DIGITS = 4,
  parameter int RES_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] residue,
  output logic             is_divisible,
  output logic [CNT_W-1:0] digit_count,
  output logic             truncated,
  output logic             bcd_error
);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [RES_W-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trunc_q;
  logic             err_q;

  logic [RES_W-1:0] res_d;
  logic [CNT_W-1:0] cnt_d;
  logic             beat;
  logic             done;
  logic             digit_err;

  assign beat  = in_valid & in_ready_q;
  assign cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign done  = in_last | (cnt_d == CNT_W'(MAX_DIGITS));

`ifdef BCD_STREAM_ERR_CHECK_EN
  assign digit_err = (in_digit > 4'(BCD_MAX));
`else
  assign digit_err = 1'b0;
`endif

  // A fresh number starts from residue zero regardless of what is held.
  bcd_mod_step #(
    .DIVISOR (DIVISOR),
    .RES_W   (RES_W)
  ) u_step (
    .r_i   ((state_q == IDLE) ? '0 : res_q),
    .d_i   (in_digit),
    .mod_o (res_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            res_q <= res_d;
            cnt_q <= cnt_d;
            err_q <= ((state_q == ACCUM) & err_q) | digit_err;
            if (done) begin
              state_q     <= RESULT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              trunc_q     <= ~in_last;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            trunc_q     <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign residue      = res_q;
  assign digit_count  = cnt_q;
  assign truncated    = trunc_q;
  assign is_divisible = out_valid_q & ~err_q & (res_q == '0);
  assign bcd_error    = out_valid_q & err_q;

endmodule : bcd_stream_mod_checker

// File: doc/bcd_stream_mod_checker.md
Name: bcd_stream_mod_checker

Overview:
- Sequential, parametrised successor to the combinational four-digit BCD divisible-by-3 checker.
- Accepts a decimal number as a stream of BCD digits, most significant digit first, one per valid/ready beat.
- Maintains a running residue modulo DIVISOR and reports divisibility once the number ends.
- Sits between a digit source (keypad or serial BCD bus) and downstream result logic; both sides use valid/ready.

Parameters:
- DIVISOR, 3, modulus under test; legal range 2..15.
- MAX_DIGITS, 4, maximum digits per number; legal range 1..255; the stream auto-terminates at this count.
- RES_W, 4, residue width; must satisfy 2^RES_W >= DIVISOR.
- CNT_W, 8, digit-counter width; must satisfy 2^CNT_W > MAX_DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  digit beat valid.
- in_ready  out  1  block can accept a digit.
- in_digit  in  4  BCD digit, 0..9.
- in_last  in  1  marks the final digit of the number.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- residue  out  RES_W  number mod DIVISOR.
- is_divisible  out  1  residue == 0 and no error.
- digit_count  out  CNT_W  digits consumed for this number.
- truncated  out  1  number ended by MAX_DIGITS, not by in_last.
- bcd_error  out  1  sticky invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally):
  - state = IDLE.
  - All outputs 0 except in_ready, which is 1.
  - Internal residue and count are 0.
- FSM states: IDLE, ACCUM, RESULT.
  - IDLE: in_ready = 1. On an accepted beat (in_valid & in_ready):
    - r <= (0*10 + d) mod DIVISOR; count <= 1.
    - Go to RESULT if in_last or MAX_DIGITS == 1; otherwise go to ACCUM.
  - ACCUM: in_ready = 1. On each accepted beat:
    - r <= (r*10 + d) mod DIVISOR; count <= count + 1.
    - Go to RESULT if in_last or the new count == MAX_DIGITS.
  - RESULT: in_ready = 0 and out_valid = 1.
    - All result outputs are held stable until out_valid & out_ready, then go to IDLE.
    - in_ready rises in the cycle after the handshake; there is no same-cycle turnaround.
- Step arithmetic:
  - r*10 + d is at most 149 and is computed in 8 bits.
  - The mod is combinational within the step, using conditional subtraction of DIVISOR*8, *4, *2, *1.
  - One digit per cycle; no bubbles while in_valid is held high.
- Latency: out_valid asserts in the cycle after the final digit is accepted.
- Result fields:
  - digit_count = count.
  - truncated = 1 only when the MAX_DIGITS limit ended the number and in_last was 0 on that beat.
  - If in_last arrives exactly on digit MAX_DIGITS, truncated = 0.
- Input rules:
  - in_digit and in_last are ignored when in_valid = 0.
  - There is no empty number: every number contains at least one digit.
- Leading zeros are legal and counted; they do not change the residue.
- Reset mid-stream discards the partial residue and count; no result is emitted.

Optional Feature:
- Macro: BCD_STREAM_ERR_CHECK_EN.
- Defined:
  - A digit > 9 accepted in IDLE or ACCUM sets an internal sticky error. The digit is still counted and folded into the residue.
  - At RESULT, bcd_error = 1 and is_divisible is forced to 0.
  - The error clears on the transition from RESULT to IDLE and on reset.
- Undefined:
  - bcd_error is tied to 0.
  - Digits > 9 are folded arithmetically as their binary value (10..15) with no flag.

Decomposition:
- Package bcd_stream_pkg holds:
  - state enum (IDLE, ACCUM, RESULT);
  - localparam BCD_MAX = 9;
  - localparam STEP_W = 8.
- One sub-module: bcd_mod_step.
  - Combinational, parametrised by DIVISOR and RES_W.
  - Inputs r and d; output (r*10 + d) mod DIVISOR.
  - Reusable by a future multi-channel variant.

Test Plan:
- DIVISOR=3: digits 1,2,3 with in_last on 3, out_ready=1 → next cycle out_valid=1, residue=0, is_divisible=1, digit_count=3, truncated=0.
- DIVISOR=3: digits 1,2,4 with last → residue=1, is_divisible=0. Then DIVISOR=7: digits 0,4,9 with last → residue=0, is_divisible=1, digit_count=3.
- DIVISOR=3, MAX_DIGITS=4: digits 9,9,9,9,(5) with in_last never asserted → result after the 4th digit: residue=0, is_divisible=1, digit_count=4, truncated=1; in_ready=0 while the 5th digit waits. Repeat with in_last on the 4th digit → truncated=0.
- Backpressure: result ready, out_ready low for 3 cycles → out_valid and all fields stable for those cycles; in_ready=0; in_ready=1 the cycle after the handshake.
- Reset mid-stream: assert rst_n=0 after digits 1,2 (no last) → in_ready=1, out_valid=0. Then digits 6 with last → residue=0, digit_count=1.
- With BCD_STREAM_ERR_CHECK_EN: digits 3,0xA,0 with last → bcd_error=1, is_divisible=0. The next number (digit 3 with last) → bcd_error=0, is_divisible=1.
